count_burst_len: RTL and testbench
==================================

# count_burst_len

Burst-length recovery block for the memory-interface datapath. It consumes a per-beat `last` flag stream, counts the beats of each burst, and emits one burst length per burst, encoded as beats minus one. It performs the inverse of the burst-length-to-last expansion on the write/read channel. It sits between a beat-level stream (e.g. AXI `last` tap) and a FIFO-style burst-length queue, and has a registered output stage.

## Interface
- `BurstLenWidth`, default 8: width W of the burst-length field; the emitted value is beats-1.
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst  in  1`: reset; asynchronous, active-high.
- `last_dout  in  1`: head-of-queue last flag; 1 marks the final beat of a burst.
- `last_empty_n  in  1`: input queue non-empty; `last_dout` is valid only while this is 1.
- `last_read  out  1`: pop input; combinational.
- `burst_len_din  out  W`: burst length (beats-1); registered.
- `burst_len_full_n  in  1`: output queue has space.
- `burst_len_write  out  1`: push output; registered.

## Operation
- State:
  - `count[W-1:0]`: beats already consumed in the current burst.
  - `pending`: output register holds an unwritten value.
  - `pending_len[W-1:0]`: the held value.
- Output drive: `burst_len_write = pending` and `burst_len_din = pending_len`.
- `drain` = `pending & burst_len_full_n`; when `drain` is 1, `pending` clears this cycle unless it is reloaded.
- `completing` = `last_dout`, OR-ed with (`count == {W{1'b1}}`) when split is compiled in.
- `last_read` = `last_empty_n & (~completing | ~pending | burst_len_full_n)`:
  - Non-completing beats are never stalled by output backpressure.
  - `last_read` is forced to 0 while `rst` is asserted.
- On a read of a non-completing beat: `count <= count + 1` (modulo 2^W).
- On a read of a completing beat:
  - `pending <= 1`, `pending_len <= count`, `count <= 0`.
  - A simultaneous drain and load is legal: the old value is written and the new one is held.
- With no read and no drain, all state holds. Gaps in `last_empty_n` preserve `count`.
- No FSM beyond the `pending` bit. There are effectively two states, IDLE (`pending`=0) and HOLD (`pending`=1):
  - IDLE→HOLD on a completing read.
  - HOLD→IDLE on a drain without a completing read.
  - HOLD→HOLD on a drain together with a completing read.

## Timing
- Reset values: `count`=0, `pending`=0, `pending_len`=0. So `burst_len_write`=0, `burst_len_din`=0, and `last_read`=0 during reset.
- Reset takes effect immediately and asynchronously, including mid-burst: any partial count and any held output are discarded.
- Latency: `burst_len_write` asserts in the cycle after the completing beat is read.
- Throughput: one beat per cycle. Back-to-back single-beat bursts sustain one output per cycle while `burst_len_full_n`=1.
- Backpressure: a completing beat at the head while `pending`=1 and `burst_len_full_n`=0 is not popped. `last_read`=0 until space appears.
- `last_read` may depend combinationally on `last_dout`, `last_empty_n` and `burst_len_full_n`. Its only internal dependencies are registered state.

## Configuration
- `COUNT_BURST_LEN_SPLIT_EN` defined:
  - When a beat is read at `count == {W{1'b1}}`, the burst is force-terminated and all-ones (2^W beats) is emitted. This happens even if `last_dout`=0.
  - Counting restarts, so over-long bursts are split into legal chunks.
- Undefined:
  - `count` wraps modulo 2^W and only `last_dout` ends a burst.
  - Upstream guarantees bursts of at most 2^W beats; longer bursts produce (beats-1) mod 2^W.

## Structure
- Shared package `burst_pkg`:
  - Default burst-length width constant `BURST_LEN_WIDTH_DEFAULT = 8`.
  - Typedef `burst_len_t` (logic [BURST_LEN_WIDTH_DEFAULT-1:0]).
  - Also used by the last-generation block.
- No sub-module: the counter and single-entry output register are inline. Splitting the output stage out is not warranted at this size.

## Test plan
- Lasts 0,0,0,1 with `full_n`=1 → `last_read` high 4 cycles; `burst_len_din`=3 with `burst_len_write`=1 in the cycle after the 4th read; then write drops.
- Continuous last=1 stream for 8 cycles with `full_n`=1 → `last_read`=1 every cycle; eight consecutive writes of 0.
- `pending`=1, `full_n`=0, input 0,0,1 → the two 0-beats are popped. The completing beat is held (`last_read`=0) until `full_n`=1; then the old value is written and 2 is loaded the same cycle.
- W=4, 20 beats, last on the 20th:
  - With `COUNT_BURST_LEN_SPLIT_EN`: emits 15 then 3.
  - Without it: emits a single 3.
- Assert `rst` asynchronously after 5 beats of a burst while an output is pending → outputs 0 immediately. After release, lasts 0,1 → emits 1.
- Input `last_empty_n` toggling 1,0,0,1,0,1 with lasts 0,0,1 → count preserved across gaps; emits 2.

Source files
------------

// File: rtl/burst_pkg.sv
// Shared burst-length definitions for the burst-length/last conversion blocks.
package burst_pkg;

  localparam int BURST_LEN_WIDTH_DEFAULT = 8;

  typedef logic [BURST_LEN_WIDTH_DEFAULT-1:0] burst_len_t;

endpackage

// File: rtl/count_burst_len.sv
// Recovers burst lengths (beats-1) from a per-beat last-flag stream.
// Define COUNT_BURST_LEN_SPLIT_EN to force-terminate bursts longer than 2^W beats.
module count_burst_len
  import burst_pkg::*;
#(
  parameter int BurstLenWidth = BURST_LEN_WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     last_dout,
  input  logic                     last_empty_n,
  output logic                     last_read,
  output logic [BurstLenWidth-1:0] burst_len_din,
  input  logic                     burst_len_full_n,
  output logic                     burst_len_write
);

  logic [BurstLenWidth-1:0] count_q, count_d;
  logic [BurstLenWidth-1:0] pending_len_q, pending_len_d;
  logic                     pending_q, pending_d;
  logic                     drain;
  logic                     completing;

  always_comb begin
    drain = pending_q & burst_len_full_n;
`ifdef COUNT_BURST_LEN_SPLIT_EN
    completing = last_dout | (count_q == '1);
`else
    completing = last_dout;
`endif
    // Only a completing beat needs the output register, so only it can stall.
    last_read = ~rst & last_empty_n & (~completing | ~pending_q | burst_len_full_n);

    count_d       = count_q;
    pending_d     = pending_q;
    pending_len_d = pending_len_q;
    if (drain) begin
      pending_d = 1'b0;
    end
    if (last_read) begin
      if (completing) begin
        pending_d     = 1'b1;
        pending_len_d = count_q;
        count_d       = '0;
      end else begin
        count_d = count_q + BurstLenWidth'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q       <= '0;
      pending_q     <= 1'b0;
      pending_len_q <= '0;
    end else begin
      count_q       <= count_d;
      pending_q     <= pending_d;
      pending_len_q <= pending_len_d;
    end
  end

  assign burst_len_write = pending_q;
  assign burst_len_din   = pending_len_q;

endmodule

// File: tb/tb_count_burst_len.sv
// Scoreboard bench for count_burst_len at W=4; expectations follow the split macro.
module tb_count_burst_len;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         last_dout;
  logic         last_empty_n;
  logic         last_read;
  logic [W-1:0] burst_len_din;
  logic         burst_len_full_n;
  logic         burst_len_write;

  int n_vec;
  int n_bad;
  int exp_q[$];

  count_burst_len #(.BurstLenWidth(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .last_dout        (last_dout),
    .last_empty_n     (last_empty_n),
    .last_read        (last_read),
    .burst_len_din    (burst_len_din),
    .burst_len_full_n (burst_len_full_n),
    .burst_len_write  (burst_len_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Expected outputs for one burst of n beats.
  task automatic push_burst(input int n);
    int r;
    r = n;
`ifdef COUNT_BURST_LEN_SPLIT_EN
    while (r > (1 << W)) begin
      exp_q.push_back((1 << W) - 1);
      r -= (1 << W);
    end
    exp_q.push_back(r - 1);
`else
    exp_q.push_back((r - 1) % (1 << W));
`endif
  endtask

  // Present one beat and wait for it to be popped; every beat here must go immediately.
  task automatic beat(input logic l);
    int cyc;
    last_empty_n = 1'b1;
    last_dout    = l;
    @(negedge clk);
    chk("rd_immediate", int'(last_read), 1);
    cyc = 0;
    while (!last_read && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!last_read) chk("rd_timeout", 0, 1);
    @(posedge clk);
    #1;
    last_empty_n = 1'b0;
    last_dout    = 1'b0;
  endtask

  task automatic burst(input int n);
    push_burst(n);
    for (int i = 1; i <= n; i++) beat(i == n);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: a push happens on every edge where write and full_n are both high.
  always @(negedge clk) begin
    if (!rst && burst_len_write && burst_len_full_n) begin
      if (exp_q.size() == 0) chk("sb_extra_write", int'(burst_len_din), -1);
      else chk("sb_len", int'(burst_len_din), exp_q.pop_front());
    end
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    last_dout = 1'b1;
    last_empty_n = 1'b1;
    burst_len_full_n = 1'b1;

    @(negedge clk);
    chk("rst_write", int'(burst_len_write), 0);
    chk("rst_din", int'(burst_len_din), 0);
    chk("rst_read", int'(last_read), 0);
    last_empty_n = 1'b0;
    last_dout = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // 4-beat burst: latency and single-cycle write.
    burst(4);
    @(negedge clk);
    chk("lat_write", int'(burst_len_write), 1);
    chk("lat_din", int'(burst_len_din), 3);
    @(negedge clk);
    chk("write_drop", int'(burst_len_write), 0);
    idle(2);

    // Back-to-back single-beat bursts.
    for (int i = 0; i < 8; i++) burst(1);
    idle(3);

    // Backpressure: hold a 0, feed 0,0 then a completing beat.
    burst_len_full_n = 1'b0;
    burst(1);
    exp_q.push_back(2);
    beat(1'b0);
    beat(1'b0);
    last_empty_n = 1'b1;
    last_dout = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_stall", int'(last_read), 0);
      chk("bp_hold", int'(burst_len_write), 1);
    end
    @(posedge clk);
    #1;
    burst_len_full_n = 1'b1;
    @(negedge clk);
    chk("bp_release", int'(last_read), 1);
    @(posedge clk);
    #1;
    last_empty_n = 1'b0;
    last_dout = 1'b0;
    @(negedge clk);
    chk("bp_reload", int'(burst_len_write), 1);
    idle(3);

    // Over-long burst of 20 beats.
    burst(20);
    idle(3);

    // Asynchronous reset mid-burst with an output held.
    burst_len_full_n = 1'b0;
    for (int i = 0; i < 6; i++) beat(i == 0);
    last_empty_n = 1'b1;
    last_dout = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("arst_write", int'(burst_len_write), 0);
    chk("arst_din", int'(burst_len_din), 0);
    chk("arst_read", int'(last_read), 0);
    last_empty_n = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    burst_len_full_n = 1'b1;
    idle(1);
    burst(2);
    idle(3);

    // Gaps in last_empty_n preserve the count; last_dout is junk while empty.
    push_burst(3);
    beat(1'b0);
    last_dout = 1'b1;
    idle(2);
    beat(1'b0);
    last_dout = 1'b1;
    idle(1);
    beat(1'b1);
    idle(4);

    chk("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

endmodule
